// File: rtl/fxp_requant_pipe_if.sv
// fxp_requant_pipe_if: handshake, config and status bundle
// for the per-channel fixed-point requantizer.
interface fxp_requant_pipe_if #(
  parameter int NIN     = 32,
  parameter int NOUT    = 8,
  parameter int NCH     = 4,
  parameter int MULT_W  = 16,
  parameter int SHIFT_W = 5
);
  localparam int CHW = $clog2(NCH);

  logic               in_valid;
  logic               in_ready;
  logic [NIN-1:0]     in_data;
  logic [CHW-1:0]     in_ch;
  logic               cfg_we;
  logic [CHW-1:0]     cfg_ch;
  logic [MULT_W-1:0]  cfg_mult;
  logic [SHIFT_W-1:0] cfg_shift;
  logic               out_valid;
  logic               out_ready;
  logic [NOUT-1:0]    out_data;
  logic               out_sat;
  logic [15:0]        sat_count;

  modport slave (
    input  in_valid, in_data, in_ch,
    input  cfg_we, cfg_ch, cfg_mult, cfg_shift,
    input  out_ready,
    output in_ready, out_valid, out_data,
    output out_sat, sat_count
  );

  modport master (
    output in_valid, in_data, in_ch,
    output cfg_we, cfg_ch, cfg_mult, cfg_shift,
    output out_ready,
    input  in_ready, out_valid, out_data,
    input  out_sat, sat_count
  );
endinterface

// File: rtl/fxp_requant_pipe.sv
// fxp_requant_pipe: 3-stage per-channel requantizer, sat(rnd((x*m)>>>s)).
// Optional saturation counter: define FXP_REQUANT_SATCNT_EN.
module fxp_requant_pipe #(
  parameter int NIN     = 32,
  parameter int NOUT    = 8,
  parameter int NCH     = 4,
  parameter int MULT_W  = 16,
  parameter int SHIFT_W = 5
) (
  input logic clk,
  input logic rst_n,
  fxp_requant_pipe_if.slave bus
);
  localparam int PW = NIN + MULT_W;
  localparam int QW = PW + 1;

  localparam logic signed [QW-1:0] QMAX =
    QW'((64'sd1 <<< (NOUT - 1)) - 64'sd1);
  localparam logic signed [QW-1:0] QMIN =
    QW'(-(64'sd1 <<< (NOUT - 1)));

  typedef struct packed {
    logic [MULT_W-1:0]  mult;
    logic [SHIFT_W-1:0] shift;
  } coef_t;

  typedef struct packed {
    logic           v;
    logic [NIN-1:0] data;
    coef_t          coef;
  } s1_t;

  typedef struct packed {
    logic               v;
    logic [PW-1:0]      prod;
    logic [SHIFT_W-1:0] shift;
  } s2_t;

  coef_t bank [NCH];
  s1_t   s1;
  s2_t   s2;
  logic  adv;

  // whole pipe moves together; a free output slot frees every stage
  assign adv          = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = adv;

  // coefficient bank, written independently of the data path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        bank[i] <= '{mult: MULT_W'(1), shift: '0};
      end
    end else if (bus.cfg_we) begin
      bank[bus.cfg_ch] <= '{mult: bus.cfg_mult, shift: bus.cfg_shift};
    end
  end

  // S1: capture beat with its coefficients snapshot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
    end else if (adv) begin
      s1.v <= bus.in_valid;
      if (bus.in_valid) begin
        s1.data <= bus.in_data;
        s1.coef <= bank[bus.in_ch];
      end
    end
  end

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] m_ext;
  logic signed [PW-1:0] prod_c;

  assign a_ext  = {{MULT_W{s1.data[NIN-1]}}, s1.data};
  assign m_ext  = {{NIN{s1.coef.mult[MULT_W-1]}}, s1.coef.mult};
  assign prod_c = a_ext * m_ext;

  // S2: full-width signed product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2 <= '0;
    end else if (adv) begin
      s2.v <= s1.v;
      if (s1.v) begin
        s2.prod  <= prod_c;
        s2.shift <= s1.coef.shift;
      end
    end
  end

  logic signed [QW-1:0] p_ext;
  logic signed [QW-1:0] rnd;
  logic signed [QW-1:0] sum;
  logic signed [QW-1:0] q;
  logic                 sat_hi;
  logic                 sat_lo;
  logic [NOUT-1:0]      res;

  // half-up rounding: add half an LSB, then floor via arithmetic shift
  always_comb begin
    p_ext = {s2.prod[PW-1], s2.prod};
    rnd   = '0;
    if (s2.shift != '0) begin
      rnd = QW'(1) << (s2.shift - SHIFT_W'(1));
    end
    sum    = p_ext + rnd;
    q      = sum >>> s2.shift;
    sat_hi = q > QMAX;
    sat_lo = q < QMIN;
    res    = q[NOUT-1:0];
    if (sat_hi) begin
      res = {1'b0, {(NOUT-1){1'b1}}};
    end else if (sat_lo) begin
      res = {1'b1, {(NOUT-1){1'b0}}};
    end
  end

  // S3: registered result, held while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sat   <= 1'b0;
    end else if (adv) begin
      bus.out_valid <= s2.v;
      if (s2.v) begin
        bus.out_data <= res;
        bus.out_sat  <= sat_hi | sat_lo;
      end
    end
  end

`ifdef FXP_REQUANT_SATCNT_EN
  logic [15:0] sat_cnt;

  // sticky count of clipped beats handed downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (bus.out_valid & bus.out_ready & bus.out_sat
                 & (sat_cnt != 16'hFFFF)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end

  assign bus.sat_count = sat_cnt;
`else
  assign bus.sat_count = '0;
`endif
endmodule

// File: tb/tb_fxp_requant_pipe.sv
// tb_fxp_requant_pipe: randomized + directed scoreboard bench
// for fxp_requant_pipe against a plain-arithmetic model.
module tb_fxp_requant_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fxp_requant_pipe_if #(
    .NIN(32), .NOUT(8), .NCH(4), .MULT_W(16), .SHIFT_W(5)
  ) bus ();

  fxp_requant_pipe #(
    .NIN(32), .NOUT(8), .NCH(4), .MULT_W(16), .SHIFT_W(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    int d;
    bit s;
    int acc_cyc;
    bit lat;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mult_m[4];
  int   shift_m[4];
  bit   lat_mode = 1'b0;
  int   rdy_mode = 0;
  int   sat_seen = 0;
  bit   hold_pend = 1'b0;
  int   held_d = 0;
  bit   held_s = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act,
                       input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // reference: exact integer arithmetic of the requant rule
  function automatic void model(input int d, input int m,
                                input int s, output int q,
                                output bit sat);
    longint p;
    longint r;
    p = longint'(d) * longint'(m);
    if (s == 0) r = p;
    else r = (p + (longint'(1) <<< (s - 1))) >>> s;
    sat = 1'b0;
    q = int'(r);
    if (r > 127) begin q = 127; sat = 1'b1; end
    else if (r < -128) begin q = -128; sat = 1'b1; end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mult_m[i] = 1;
      shift_m[i] = 0;
    end
  endtask

  // one clock of stimulus; sampled 1ns before the rising edge
  task automatic step(input bit v, input int d, input int ch,
                      input bit we, input int wch, input int wm,
                      input int ws, output bit acc, output bit rdy);
    exp_t e;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = 32'(d);
    bus.in_ch     = 2'(ch);
    bus.cfg_we    = we;
    bus.cfg_ch    = 2'(wch);
    bus.cfg_mult  = 16'(wm);
    bus.cfg_shift = 5'(ws);
    #4;
    rdy = bus.in_ready;
    acc = bus.in_valid && bus.in_ready;
    if (acc) begin
      model(d, mult_m[ch], shift_m[ch], e.d, e.s);
      e.acc_cyc = cyc;
      e.lat = lat_mode;
      sbq.push_back(e);
    end
    if (we) begin
      mult_m[wch] = wm;
      shift_m[wch] = ws;
    end
  endtask

  task automatic idle(input int n);
    bit a;
    bit r;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, a, r);
  endtask

  task automatic send(input int d, input int ch);
    bit a;
    bit r;
    int tries;
    tries = 0;
    a = 1'b0;
    while (!a && tries < 200) begin
      step(1, d, ch, 0, 0, 0, 0, a, r);
      tries++;
    end
    if (!a) check("send_timeout", 0, 1);
  endtask

  task automatic cfg(input int ch, input int m, input int s);
    bit a;
    bit r;
    step(0, 0, 0, 1, ch, m, s, a, r);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 400) begin
      idle(1);
      n++;
    end
    if (sbq.size() != 0) check("drain_timeout", sbq.size(), 0);
  endtask

  // downstream ready pattern
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      case (rdy_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = ($urandom % 4) != 0;
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // monitor: pops on handshake, checks hold stability on stall
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          check("hold_valid", bus.out_valid, 1);
          check("hold_data", $signed(bus.out_data), held_d);
          check("hold_sat", bus.out_sat, held_s);
          hold_pend = 1'b0;
        end
        if (bus.out_valid && bus.out_ready) begin
          if (sbq.size() == 0) begin
            check("unexpected_out", $signed(bus.out_data), 999);
          end else begin
            e = sbq.pop_front();
            check("out_data", $signed(bus.out_data), e.d);
            check("out_sat", bus.out_sat, e.s);
            if (e.lat) check("latency", cyc - e.acc_cyc, 3);
            if (e.s) sat_seen++;
          end
        end else if (bus.out_valid) begin
          hold_pend = 1'b1;
          held_d = $signed(bus.out_data);
          held_s = bus.out_sat;
        end
      end
    end
  end

  initial begin
    bit a;
    bit r;
    bit stalled;
    int sent;
    int k;
    int d;
    int m;
    int s;
    logic signed [15:0] m16;
    int exp_cnt;

    bus.in_valid = 0;
    bus.in_data = '0;
    bus.in_ch = '0;
    bus.cfg_we = 0;
    bus.cfg_ch = '0;
    bus.cfg_mult = '0;
    bus.cfg_shift = '0;
    model_reset();

    #12;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_sat", bus.out_sat, 0);
    check("rst_sat_count", bus.sat_count, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // defaults: identity with saturation
    lat_mode = 1'b1;
    send(100, 0);
    send(-5, 0);
    send(200, 0);
    send(-300, 0);
    drain();

    // shift 7 with rounding
    cfg(0, 1, 7);
    send(0, 0);
    send(16384, 0);
    send(-25600, 0);
    send(8192, 0);
    send(192, 0);
    send(-192, 0);
    send(-64, 0);
    drain();

    // per-channel coefficients interleaved
    cfg(1, 3, 2);
    cfg(2, -2, 0);
    send(10, 1);
    send(10, 2);
    send(100, 2);
    drain();
    lat_mode = 1'b0;

    // backpressure: stall cycles 3..8, then random ready
    cfg(0, 1, 0);
    sent = 0;
    k = 0;
    stalled = 1'b0;
    while (sent < 10 && k < 200) begin
      if (k < 3) rdy_mode = 0;
      else if (k <= 8) rdy_mode = 2;
      else rdy_mode = 1;
      step(1, sent + 1, 0, 0, 0, 0, 0, a, r);
      if (a) sent++;
      if (!r) stalled = 1'b1;
      k++;
    end
    check("bp_sent", sent, 10);
    check("bp_in_ready_dropped", stalled, 1);
    drain();

    // random traffic, random coefficients, random ready
    rdy_mode = 1;
    for (int i = 0; i < 500; i++) begin
      case ($urandom % 3)
        0: d = int'($urandom_range(0, 2000)) - 1000;
        1: d = int'($urandom);
        default: d = int'($urandom_range(0, 2097152)) - 1048576;
      endcase
      m16 = 16'($urandom);
      m = ($urandom % 2) ? int'(m16)
                         : int'($urandom_range(0, 16)) - 8;
      s = ($urandom % 2) ? int'($urandom_range(0, 31))
                         : int'($urandom_range(0, 8));
      step(($urandom % 4) != 0, d, int'($urandom % 4),
           ($urandom % 8) == 0, int'($urandom % 4), m, s, a, r);
    end
    drain();
    rdy_mode = 0;
    idle(2);
`ifdef FXP_REQUANT_SATCNT_EN
    exp_cnt = (sat_seen > 65535) ? 65535 : sat_seen;
`else
    exp_cnt = 0;
`endif
    check("sat_count_random", bus.sat_count, exp_cnt);

    // config write on the accepting edge uses old coefficients
    cfg(0, 1, 0);
    lat_mode = 1'b1;
    step(1, 50, 0, 1, 0, 2, 0, a, r);
    check("race_accept", a, 1);
    send(50, 0);
    drain();
    lat_mode = 1'b0;

    // asynchronous reset with beats in flight
    send(1, 0);
    send(2, 0);
    send(3, 0);
    @(negedge clk);
    bus.in_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    sbq.delete();
    model_reset();
    sat_seen = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(6);
    check("post_rst_sat_count", bus.sat_count, 0);

    // five saturating beats
    for (int i = 0; i < 5; i++) send(1000, 0);
    drain();
    idle(2);
`ifdef FXP_REQUANT_SATCNT_EN
    exp_cnt = 5;
`else
    exp_cnt = 0;
`endif
    check("sat_count_5", bus.sat_count, exp_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d required=0", sbq.size());
    $fatal(1, "timeout");
  end
endmodule
